// File: rtl/ppu_sparse_compressor.sv
// Post-processing stage ahead of the activation RAM: shift, saturate, optional ReLU,
// then zero-run compression of each dense beat into (value, run) slots packed from slot 0.
module ppu_sparse_compressor #(
    parameter int NUM_LANES      = 4,
    parameter int ACC_W          = 24,
    parameter int SHIFT          = 8,
    parameter int MAX_COMPRESSED = 64,
    parameter int RELU_EN        = 1,
    localparam int CNT_W         = $clog2(MAX_COMPRESSED + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       acc_valid,
    input  logic                       acc_last,
    input  logic [NUM_LANES*ACC_W-1:0] acc_data,
    output logic [NUM_LANES-1:0]       out_valid,
    output logic [NUM_LANES*16-1:0]    out_data,
    output logic [NUM_LANES*4-1:0]     out_indices,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           entry_count,
    output logic                       overflow
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

    state_t                      state_q;
    logic                        busy_q, done_q, ovf_q, s1_valid_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [3:0]                  run_q;
    logic signed [15:0]          s1_data_q [NUM_LANES];
    logic signed [15:0]          s1_lane_d [NUM_LANES];
    logic [NUM_LANES-1:0]        out_valid_q;
    logic [NUM_LANES*16-1:0]     out_data_q;
    logic [NUM_LANES*4-1:0]      out_idx_q;

    logic                        accept_beat;
    logic [NUM_LANES-1:0]        valid_d;
    logic [NUM_LANES*16-1:0]     data_d;
    logic [NUM_LANES*4-1:0]      idx_d;
    logic [CNT_W-1:0]            cnt_d;
    logic [3:0]                  run_d;
    logic                        ovf_d;

    assign accept_beat = (state_q == RUN) && acc_valid;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic signed [ACC_W-1:0] lane_raw;
            logic signed [ACC_W-1:0] shifted;
            logic signed [15:0]      sat;
            assign lane_raw = acc_data[gi*ACC_W +: ACC_W];
            assign shifted  = lane_raw >>> SHIFT;
            assign sat = (shifted > SAT_MAX) ? 16'sh7FFF :
                         (shifted < SAT_MIN) ? 16'sh8000 : shifted[15:0];
            assign s1_lane_d[gi] = ((RELU_EN != 0) && sat[15]) ? 16'sd0 : sat;
        end
    endgenerate

    // Run length carries across lanes and beats; placeholders count against capacity.
    always_comb begin
        int   m;
        logic emit;
        logic [3:0] emit_idx;
        valid_d  = '0;
        data_d   = '0;
        idx_d    = '0;
        cnt_d    = cnt_q;
        run_d    = run_q;
        ovf_d    = ovf_q;
        m        = 0;
        emit     = 1'b0;
        emit_idx = 4'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            emit     = 1'b0;
            emit_idx = run_d;
            if (s1_data_q[i] != 16'sd0) begin
                emit  = 1'b1;
                run_d = 4'd0;
            end else if (run_d == 4'd15) begin
                emit  = 1'b1;
                run_d = 4'd0;
            end else begin
                run_d = run_d + 4'd1;
            end
            if (emit) begin
                if (cnt_d < CNT_W'(MAX_COMPRESSED)) begin
                    valid_d[m]          = 1'b1;
                    data_d[m*16 +: 16]  = s1_data_q[i];
                    idx_d[m*4 +: 4]     = emit_idx;
                    m                   = m + 1;
                    cnt_d               = cnt_d + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) s1_data_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) s1_data_q[i] <= accept_beat ? s1_lane_d[i] : 16'sd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            run_q       <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            s1_valid_q  <= accept_beat;
            out_valid_q <= s1_valid_q ? valid_d : '0;
            out_data_q  <= s1_valid_q ? data_d  : '0;
            out_idx_q   <= s1_valid_q ? idx_d   : '0;
            if (s1_valid_q) begin
                cnt_q <= cnt_d;
                run_q <= run_d;
                ovf_q <= ovf_d;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        run_q   <= '0;
                    end
                end
                RUN: begin
                    if (acc_valid && acc_last) state_q <= FLUSH;
                end
                FLUSH: begin
                    // Last beat is in stage 2 once stage 1 drains; done follows its output cycle.
                    if (!s1_valid_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    run_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_indices = out_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign entry_count = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ppu_sparse_compressor.sv
// Scoreboard bench for ppu_sparse_compressor: directed tiles push expected beats,
// a negedge monitor pops and compares every non-empty output beat.
module tb_ppu_sparse_compressor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        acc_valid = 1'b0;
    logic        acc_last = 1'b0;
    logic [95:0] acc_data = '0;
    logic [3:0]  out_valid;
    logic [63:0] out_data;
    logic [15:0] out_indices;
    logic        busy, done, overflow;
    logic [6:0]  entry_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  v;
        logic [63:0] d;
        logic [15:0] x;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ppu_sparse_compressor dut (
        .clk(clk), .rst(rst), .start(start), .acc_valid(acc_valid),
        .acc_last(acc_last), .acc_data(acc_data), .out_valid(out_valid),
        .out_data(out_data), .out_indices(out_indices), .busy(busy),
        .done(done), .entry_count(entry_count), .overflow(overflow)
    );

    function automatic logic [95:0] lanes(input logic [23:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [63:0] pk16(input logic [15:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [15:0] pk4(input logic [3:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic expect_beat(input logic [3:0] v, input logic [63:0] d, input logic [15:0] x);
        exp_t e;
        e.v = v; e.d = d; e.x = x;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid != 4'b0) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_beat: got v=%b d=%h x=%h, expected no output", out_valid, out_data, out_indices);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_valid !== e.v || out_data !== e.d || out_indices !== e.x) begin
                    n_fail++;
                    $display("FAIL out_beat: got v=%b d=%h x=%h, expected v=%b d=%h x=%h",
                             out_valid, out_data, out_indices, e.v, e.d, e.x);
                end else begin
                    $display("beat v=%b d=%h x=%h matched", out_valid, out_data, out_indices);
                end
            end
        end else if (!rst && (out_data !== 64'd0 || out_indices !== 16'd0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_out_zero: got d=%h x=%h, expected 0", out_data, out_indices);
        end
    end

    task automatic start_tile(input logic with_beat);
        start     = 1'b1;
        acc_valid = with_beat;
        acc_data  = lanes(24'd1280, 24'd1280, 24'd1280, 24'd1280);
        acc_last  = with_beat;
        @(posedge clk); #1;
        start = 1'b0; acc_valid = 1'b0; acc_last = 1'b0;
    endtask

    task automatic beat(input logic [95:0] d, input logic last);
        acc_valid = 1'b1; acc_data = d; acc_last = last;
        @(posedge clk); #1;
        acc_valid = 1'b0; acc_last = 1'b0;
    endtask

    // Called right after the last beat's accepting edge; done is due in the third cycle.
    task automatic wait_done(input string name);
        int k;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin k = i; break; end
        end
        chk({name, "_done_latency"}, 64'(k), 64'd3);
        @(negedge clk);
        chk({name, "_done_pulse_end"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle: nothing happens, acc_valid pulses ignored
        for (int i = 0; i < 10; i++) begin
            acc_valid = i[0];
            acc_data  = lanes(24'd256, 24'd256, 24'd256, 24'd256);
            @(negedge clk);
            n_checks++;
            if ({out_valid, busy, done, entry_count, overflow} !== 14'd0) begin
                n_fail++;
                $display("FAIL idle_state: got v=%b busy=%b done=%b cnt=%0d ovf=%b, expected all 0",
                         out_valid, busy, done, entry_count, overflow);
            end
        end
        acc_valid = 1'b0;
        @(posedge clk); #1;

        // Basic tile; the beat alongside start must be dropped
        start_tile(1'b1);
        @(negedge clk);
        chk("basic_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        expect_beat(4'b0011, pk16(16'd1, 16'd2, 16'd0, 16'd0), pk4(4'd0, 4'd2, 4'd0, 4'd0));
        beat(lanes(24'd256, 24'd0, 24'd0, 24'd512), 1'b1);
        wait_done("basic");
        chk("basic_entry_count", 64'(entry_count), 64'd2);
        chk("basic_overflow", {63'd0, overflow}, 64'd0);

        // Saturation / ReLU
        start_tile(1'b0);
        expect_beat(4'b0011, pk16(16'd32767, 16'd1, 16'd0, 16'd0), pk4(4'd0, 4'd2, 4'd0, 4'd0));
        beat(lanes(24'h7FFFFF, 24'h800000, 24'hFFFF00, 24'h000100), 1'b1);
        wait_done("sat");
        chk("sat_entry_count", 64'(entry_count), 64'd2);

        // Long zero run: run-15 zero entry on the 16th zero, value 3 after 4 more zeros
        start_tile(1'b0);
        for (int b = 0; b < 5; b++) begin
            if (b == 3) expect_beat(4'b0001, 64'd0, pk4(4'd15, 4'd0, 4'd0, 4'd0));
            beat(96'd0, 1'b0);
        end
        expect_beat(4'b0001, pk16(16'd3, 16'd0, 16'd0, 16'd0), pk4(4'd4, 4'd0, 4'd0, 4'd0));
        beat(lanes(24'd768, 24'd0, 24'd0, 24'd0), 1'b1);
        wait_done("longrun");
        chk("longrun_entry_count", 64'(entry_count), 64'd2);

        // Overflow: 80 entries, only 64 emitted
        start_tile(1'b0);
        for (int b = 0; b < 20; b++) begin
            if (b < 16) expect_beat(4'b1111, pk16(16'd1, 16'd2, 16'd3, 16'd4), 16'd0);
            beat(lanes(24'd256, 24'd512, 24'd768, 24'd1024), b == 19);
        end
        wait_done("ovf");
        chk("ovf_entry_count", 64'(entry_count), 64'd64);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        start_tile(1'b0);
        @(negedge clk);
        chk("ovf_cleared", {56'd0, entry_count, overflow}, 64'd0);
        expect_beat(4'b0001, pk16(16'd5, 16'd0, 16'd0, 16'd0), 16'd0);
        beat(lanes(24'd1280, 24'd0, 24'd0, 24'd0), 1'b1);
        wait_done("after_ovf");
        chk("after_ovf_entry_count", 64'(entry_count), 64'd1);

        // Reset mid-tile
        start_tile(1'b0);
        expect_beat(4'b0001, pk16(16'd1, 16'd0, 16'd0, 16'd0), pk4(4'd0, 4'd0, 4'd0, 4'd0));
        expect_beat(4'b0001, pk16(16'd1, 16'd0, 16'd0, 16'd0), pk4(4'd3, 4'd0, 4'd0, 4'd0));
        for (int b = 0; b < 3; b++) beat(lanes(24'd256, 24'd0, 24'd0, 24'd0), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_outputs", {out_valid, out_data, out_indices, busy, done, entry_count, overflow}, 64'd0);
        chk("rst_data_hi", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_done", {62'd0, done, busy}, 64'd0);
        end
        @(posedge clk); #1;
        start_tile(1'b0);
        expect_beat(4'b0001, pk16(16'd1, 16'd0, 16'd0, 16'd0), pk4(4'd2, 4'd0, 4'd0, 4'd0));
        beat(lanes(24'd0, 24'd0, 24'd256, 24'd0), 1'b1);
        wait_done("fresh");
        chk("fresh_entry_count", 64'(entry_count), 64'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
